// File: rtl/psram_arb.sv
// PSRAM arbiter: MD bus passes through combinationally; MCU accesses fill idle gaps and retry on MD contention.
// Optional PSR_ARB_BYTE_EN: honour mcu_be on MCU writes (default build: full 16-bit accesses).
module psram_arb #(
    parameter int ACC_CYC   = 4,
    parameter int GUARD_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_ce_n,
    input  logic        md_oe_n,
    input  logic [20:0] md_a,
    input  logic        mcu_req,
    input  logic        mcu_we,
    input  logic [20:0] mcu_a,
    input  logic [15:0] mcu_wd,
    input  logic [1:0]  mcu_be,
    output logic        mcu_ack,
    output logic [15:0] mcu_rd,
    output logic [20:0] psr_a,
    input  logic [15:0] psr_din,
    output logic [15:0] psr_dout,
    output logic        psr_doe,
    output logic        psr_ce_n,
    output logic        psr_oe_n,
    output logic        psr_we_n,
    output logic        psr_ub_n,
    output logic        psr_lb_n,
    output logic        md_busy
);
    typedef enum logic [2:0] {S_IDLE, S_GUARD, S_SETUP, S_STROBE, S_DONE} state_t;

    localparam logic [7:0] GUARD_LD = 8'(GUARD_CYC - 1);
    localparam logic [7:0] ACC_LD   = 8'(ACC_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        md_s1_q, md_act_q;
    logic        we_q, we_d;
    logic [20:0] a_q, a_d;
    logic [15:0] wd_q, wd_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] rd_q, rd_d;

    // NOTE: every flop, including the latched request, is reset so psr_a and mcu_rd come up as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            md_s1_q  <= 1'b0;
            md_act_q <= 1'b0;
            we_q     <= 1'b0;
            a_q      <= '0;
            wd_q     <= '0;
            be_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            md_s1_q  <= ~md_ce_n;
            md_act_q <= md_s1_q;
            we_q     <= we_d;
            a_q      <= a_d;
            wd_q     <= wd_d;
            be_q     <= be_d;
            rd_q     <= rd_d;
        end
    end

    // NOTE: all next-state values take their hold value first, so no latches can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        a_d     = a_q;
        wd_d    = wd_q;
        be_d    = be_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (!md_act_q && mcu_req) begin
                    we_d    = mcu_we;
                    a_d     = mcu_a;
                    wd_d    = mcu_wd;
                    be_d    = mcu_be;
                    cnt_d   = GUARD_LD;
                    state_d = S_GUARD;
                end
            end
            S_GUARD: begin
                if (md_act_q)           cnt_d = GUARD_LD;
                else if (cnt_q == 8'd0) state_d = S_SETUP;
                else                    cnt_d = cnt_q - 8'd1;
            end
            S_SETUP: begin
                if (md_act_q) begin
                    cnt_d   = GUARD_LD;
                    state_d = S_GUARD;
                end else begin
                    cnt_d   = ACC_LD;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (md_act_q) begin
                    cnt_d   = GUARD_LD;
                    state_d = S_GUARD;
                end else if (cnt_q == 8'd0) begin
                    if (!we_q) rd_d = psr_din;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic mcu_win, wr_en;
    assign mcu_win = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_DONE);

`ifdef PSR_ARB_BYTE_EN
    assign wr_en = |be_q;
`else
    logic unused_be;
    assign unused_be = ^be_q;
    assign wr_en     = 1'b1;
`endif

    always_comb begin
        psr_a    = a_q;
        psr_doe  = 1'b0;
        psr_ce_n = 1'b1;
        psr_oe_n = 1'b1;
        psr_we_n = 1'b1;
        psr_ub_n = 1'b0;
        psr_lb_n = 1'b0;
        // The synchronized MD flag aborts the window in the same cycle it is seen.
        if (mcu_win && we_q && !(md_act_q && state_q != S_DONE)) psr_doe = 1'b1;
        if (state_q == S_STROBE && !md_act_q) begin
            if (!we_q) begin
                psr_ce_n = 1'b0;
                psr_oe_n = 1'b0;
            end else if (wr_en) begin
                psr_ce_n = 1'b0;
                psr_we_n = 1'b0;
            end
        end
`ifdef PSR_ARB_BYTE_EN
        if (mcu_win && we_q) begin
            psr_ub_n = ~be_q[1];
            psr_lb_n = ~be_q[0];
        end
`endif
        // Raw chip-select wins immediately, covering the synchronizer delay.
        if (!md_ce_n) begin
            psr_a    = md_a;
            psr_doe  = 1'b0;
            psr_ce_n = 1'b0;
            psr_oe_n = md_oe_n;
            psr_we_n = 1'b1;
            psr_ub_n = 1'b0;
            psr_lb_n = 1'b0;
        end
    end

    assign psr_dout = wd_q;
    assign mcu_ack  = (state_q == S_DONE);
    assign mcu_rd   = rd_q;
    assign md_busy  = md_act_q;
endmodule

// File: tb/tb_psram_arb.sv
// Directed self-checking bench for psram_arb with a read-data scoreboard and strobe monitors.
module tb_psram_arb;
    logic        clk = 1'b0;
    logic        rst, md_ce_n, md_oe_n, mcu_req, mcu_we;
    logic [20:0] md_a, mcu_a, psr_a;
    logic [15:0] mcu_wd, mcu_rd, psr_din, psr_dout;
    logic [1:0]  mcu_be;
    logic        mcu_ack, psr_doe, psr_ce_n, psr_oe_n, psr_we_n, psr_ub_n, psr_lb_n, md_busy;

    always #5 clk = ~clk;

    psram_arb dut (
        .clk(clk), .rst(rst), .md_ce_n(md_ce_n), .md_oe_n(md_oe_n), .md_a(md_a),
        .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_a(mcu_a), .mcu_wd(mcu_wd), .mcu_be(mcu_be),
        .mcu_ack(mcu_ack), .mcu_rd(mcu_rd), .psr_a(psr_a), .psr_din(psr_din),
        .psr_dout(psr_dout), .psr_doe(psr_doe), .psr_ce_n(psr_ce_n), .psr_oe_n(psr_oe_n),
        .psr_we_n(psr_we_n), .psr_ub_n(psr_ub_n), .psr_lb_n(psr_lb_n), .md_busy(md_busy)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    logic        cur_we;

    // Monitors sample on the falling edge, halfway between active edges.
    int          ack_cnt = 0, we_low_cnt = 0, oe_low_cnt = 0, doe_cnt = 0, doe_md_cnt = 0;
    logic [20:0] wr_a = '0;
    logic [15:0] wr_d = '0;
    logic        wr_ub = 1'b0, wr_lb = 1'b0;

    always @(negedge clk) begin
        if (mcu_ack) ack_cnt <= ack_cnt + 1;
        if (psr_doe) doe_cnt <= doe_cnt + 1;
        if (psr_doe && !md_ce_n) doe_md_cnt <= doe_md_cnt + 1;
        if (!psr_ce_n && !psr_oe_n && md_ce_n) oe_low_cnt <= oe_low_cnt + 1;
        if (!psr_we_n) begin
            we_low_cnt <= we_low_cnt + 1;
            wr_a  <= psr_a;
            wr_d  <= psr_dout;
            wr_ub <= psr_ub_n;
            wr_lb <= psr_lb_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [20:0] a, input logic [15:0] wd,
                             input logic [1:0] be, input logic [15:0] rd_exp);
        mcu_req = 1'b1;
        mcu_we  = we;
        mcu_a   = a;
        mcu_wd  = wd;
        mcu_be  = be;
        cur_we  = we;
        if (!we) exp_q.push_back(rd_exp);
    endtask

    task automatic wait_ack(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            tick();
            n++;
            if (mcu_ack) break;
        end
        if (!mcu_ack) begin
            check("ack_timeout", 32'd0, 32'd1);
            n = -1;
        end else if (!cur_we && exp_q.size() > 0) begin
            check("mcu_rd", 32'(mcu_rd), 32'(exp_q.pop_front()));
        end
        mcu_req = 1'b0;
    endtask

    int lat, a0, w0, o0, d0, m0;

    initial begin
        rst = 1'b1; md_ce_n = 1'b1; md_oe_n = 1'b1; md_a = '0;
        mcu_req = 1'b0; mcu_we = 1'b0; mcu_a = '0; mcu_wd = '0; mcu_be = 2'b11;
        psr_din = '0; cur_we = 1'b0;
        repeat (3) tick();
        check("rst_ce_n", 32'(psr_ce_n), 32'd1);
        check("rst_oe_n", 32'(psr_oe_n), 32'd1);
        check("rst_we_n", 32'(psr_we_n), 32'd1);
        check("rst_ublb", 32'({psr_ub_n, psr_lb_n}), 32'd0);
        check("rst_doe", 32'(psr_doe), 32'd0);
        check("rst_psr_a", 32'(psr_a), 32'd0);
        check("rst_ack", 32'(mcu_ack), 32'd0);
        check("rst_rd", 32'(mcu_rd), 32'd0);
        check("rst_busy", 32'(md_busy), 32'd0);
        rst = 1'b0;
        tick();

        // Uncontended read
        a0 = ack_cnt; o0 = oe_low_cnt;
        psr_din = 16'hBEEF;
        start_req(1'b0, 21'h000123, 16'h0, 2'b11, 16'hBEEF);
        wait_ack(50, lat);
        check("rd_latency", 32'(lat), 32'd8);
        tick();
        check("rd_ack_once", 32'(ack_cnt - a0), 32'd1);
        check("rd_oe_cycles", 32'(oe_low_cnt - o0), 32'd4);

        // Uncontended write at top address
        a0 = ack_cnt; w0 = we_low_cnt; d0 = doe_cnt;
        start_req(1'b1, 21'h1FFFFF, 16'h1234, 2'b11, 16'h0);
        wait_ack(50, lat);
        check("wr_latency", 32'(lat), 32'd8);
        tick();
        check("wr_ack_once", 32'(ack_cnt - a0), 32'd1);
        check("wr_we_cycles", 32'(we_low_cnt - w0), 32'd4);
        check("wr_doe_cycles", 32'(doe_cnt - d0), 32'd6);
        check("wr_addr", 32'(wr_a), 32'h1FFFFF);
        check("wr_data", 32'(wr_d), 32'h1234);
        check("rd_held", 32'(mcu_rd), 32'hBEEF);

        // MD claims the chip in the 2nd STROBE cycle of a read
        a0 = ack_cnt;
        psr_din = 16'h5A5A;
        start_req(1'b0, 21'h000777, 16'h0, 2'b11, 16'h5A5A);
        repeat (5) tick();
        check("pre_md_oe", 32'(psr_oe_n), 32'd0);
        check("pre_md_a", 32'(psr_a), 32'h000777);
        md_ce_n = 1'b0; md_oe_n = 1'b0; md_a = 21'h0ABCDE;
        #1;
        check("md_oe_pass", 32'(psr_oe_n), 32'd0);
        check("md_a_pass", 32'(psr_a), 32'h0ABCDE);
        check("md_we_n", 32'(psr_we_n), 32'd1);
        md_oe_n = 1'b1;
        #1;
        check("md_oe_follow", 32'(psr_oe_n), 32'd1);
        repeat (5) tick();
        check("md_busy_on", 32'(md_busy), 32'd1);
        check("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
        md_ce_n = 1'b1;
        wait_ack(50, lat);
        check("retry_latency", 32'(lat), 32'd9);
        tick();
        check("retry_ack_once", 32'(ack_cnt - a0), 32'd1);

        // MD holds the chip for 100 cycles with a write pending
        a0 = ack_cnt; w0 = we_low_cnt; m0 = doe_md_cnt;
        md_ce_n = 1'b0;
        repeat (3) tick();
        start_req(1'b1, 21'h000456, 16'hC0DE, 2'b11, 16'h0);
        repeat (100) tick();
        check("hold_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("hold_no_we", 32'(we_low_cnt - w0), 32'd0);
        md_ce_n = 1'b1;
        wait_ack(50, lat);
        check("hold_latency", 32'(lat), 32'd10);
        tick();
        check("hold_ack_once", 32'(ack_cnt - a0), 32'd1);
        check("hold_we_cycles", 32'(we_low_cnt - w0), 32'd4);
        check("doe_during_md", 32'(doe_md_cnt - m0), 32'd0);
        check("md_busy_off", 32'(md_busy), 32'd0);

`ifdef PSR_ARB_BYTE_EN
        start_req(1'b1, 21'h000010, 16'hAAAA, 2'b01, 16'h0);
        wait_ack(50, lat);
        tick();
        check("be01_lb", 32'(wr_lb), 32'd0);
        check("be01_ub", 32'(wr_ub), 32'd1);
        a0 = ack_cnt; w0 = we_low_cnt;
        start_req(1'b1, 21'h000011, 16'h5555, 2'b00, 16'h0);
        wait_ack(50, lat);
        tick();
        check("be00_no_we", 32'(we_low_cnt - w0), 32'd0);
        check("be00_ack", 32'(ack_cnt - a0), 32'd1);
`else
        w0 = we_low_cnt;
        start_req(1'b1, 21'h000010, 16'hAAAA, 2'b01, 16'h0);
        wait_ack(50, lat);
        tick();
        check("be_ignored_we", 32'(we_low_cnt - w0), 32'd4);
        check("be_ignored_ublb", 32'({wr_ub, wr_lb}), 32'd0);
`endif

        // Reset during STROBE of a write
        a0 = ack_cnt;
        start_req(1'b1, 21'h000321, 16'hFACE, 2'b11, 16'h0);
        repeat (5) tick();
        check("pre_rst_we", 32'(psr_we_n), 32'd0);
        rst = 1'b1; mcu_req = 1'b0;
        tick();
        check("rst_mid_we", 32'(psr_we_n), 32'd1);
        check("rst_mid_ce", 32'(psr_ce_n), 32'd1);
        check("rst_mid_doe", 32'(psr_doe), 32'd0);
        check("rst_mid_rd", 32'(mcu_rd), 32'd0);
        rst = 1'b0;
        repeat (20) tick();
        check("rst_mid_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
